// File: rtl/decod_pkg.sv
// Shared definitions for the registered 3-to-8 pulse decoder:
// FSM state encoding and code/one-hot widths.
package decod_pkg;

  typedef enum logic {
    REPOSO = 1'b0,
    ACTIVO = 1'b1
  } estado_t;

  localparam int ANCHO_COD    = 3;
  localparam int ANCHO_ONEHOT = 8;

endpackage

// File: rtl/decodificador_3a8_pulsos_if.sv
// Handshake/bus bundle for decodificador_3a8_pulsos.
// Optional parity signals exist only when DECOD_PARIDAD_EN is defined.
//
// Handshake: a code on e transfers on a rising edge exactly when
// e_valido && e_listo are both high in the preceding cycle. e_listo is
// combinational and never depends on e_valido; a producer may hold e_valido
// high and change e freely while e_listo is low without anything being taken.
//
// estado and codigo are read-only debug views of the FSM state and the
// latched code.
interface decodificador_3a8_pulsos_if;
  import decod_pkg::*;

  logic                    en;
  logic [ANCHO_COD-1:0]    e;
  logic                    e_valido;
  logic                    e_listo;
  logic [ANCHO_ONEHOT-1:0] s;
  logic                    s_valido;
  logic                    ocupado;
  estado_t                 estado;
  logic [ANCHO_COD-1:0]    codigo;
`ifdef DECOD_PARIDAD_EN
  logic                    e_par;
  logic                    err_par;
`endif

`ifdef DECOD_PARIDAD_EN
  modport master (
    output en, e, e_valido, e_par,
    input  e_listo, s, s_valido, ocupado, estado, codigo, err_par
  );
  modport slave (
    input  en, e, e_valido, e_par,
    output e_listo, s, s_valido, ocupado, estado, codigo, err_par
  );
`else
  modport master (
    output en, e, e_valido,
    input  e_listo, s, s_valido, ocupado, estado, codigo
  );
  modport slave (
    input  en, e, e_valido,
    output e_listo, s, s_valido, ocupado, estado, codigo
  );
`endif

endinterface

// File: rtl/decodificador_3a8.sv
// Purely combinational 3-to-8 decoder; output is all zeros when en=0.
module decodificador_3a8
  import decod_pkg::*;
(
  input  logic                    en,
  input  logic [ANCHO_COD-1:0]    e,
  output logic [ANCHO_ONEHOT-1:0] s
);

  // One-hot of e when enabled, zero otherwise
  always_comb begin
    s = '0;
    if (en) s[e] = 1'b1;
  end

endmodule

// File: rtl/decodificador_3a8_pulsos.sv
// Registered 3-to-8 decoder that holds each accepted code's one-hot line
// for ANCHO_PULSO cycles, with back-to-back reload on the final cycle.
// Optional even-parity checking on the input code: DECOD_PARIDAD_EN.
module decodificador_3a8_pulsos
  import decod_pkg::*;
#(
  parameter int ANCHO_PULSO = 4
) (
  input  logic clk,
  input  logic rst_n,
  decodificador_3a8_pulsos_if.slave bus
);

  localparam int CNT_W = $clog2(ANCHO_PULSO + 1);
  localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(ANCHO_PULSO - 1);

  estado_t                 r_estado;
  logic [CNT_W-1:0]        r_cnt;
  logic [ANCHO_COD-1:0]    r_cod;
  logic [ANCHO_ONEHOT-1:0] r_s;
  logic                    r_s_valido;
  logic                    r_ocupado;
`ifdef DECOD_PARIDAD_EN
  logic                    r_err_par;
`endif

  logic                    w_final;
  logic                    w_listo;
  logic                    w_acepta;
  logic                    w_par_ok;
  logic                    w_decoda;
  logic [ANCHO_ONEHOT-1:0] w_s_sig;

  // Final pulse cycle is the only point inside ACTIVO where a new code fits
  assign w_final  = (r_estado == ACTIVO) && (r_cnt == CNT_ULT);
  assign w_listo  = bus.en && ((r_estado == REPOSO) || w_final);
  assign w_acepta = bus.e_valido && w_listo;
`ifdef DECOD_PARIDAD_EN
  assign w_par_ok = ~(^{bus.e, bus.e_par});
`else
  assign w_par_ok = 1'b1;
`endif
  // A badly-parity code is consumed but never decoded
  assign w_decoda = w_acepta && w_par_ok;

  decodificador_3a8 u_dec (
    .en (w_decoda),
    .e  (bus.e),
    .s  (w_s_sig)
  );

  // FSM, pulse counter, code latch and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= REPOSO;
      r_cnt      <= '0;
      r_cod      <= '0;
      r_s        <= '0;
      r_s_valido <= 1'b0;
      r_ocupado  <= 1'b0;
`ifdef DECOD_PARIDAD_EN
      r_err_par  <= 1'b0;
`endif
    end else begin
`ifdef DECOD_PARIDAD_EN
      r_err_par <= w_acepta && !w_par_ok;
`endif
      case (r_estado)
        REPOSO: begin
          if (w_decoda) begin
            r_estado   <= ACTIVO;
            r_cnt      <= '0;
            r_cod      <= bus.e;
            r_s        <= w_s_sig;
            r_s_valido <= 1'b1;
            r_ocupado  <= 1'b1;
          end
        end
        ACTIVO: begin
          if (!bus.en || (w_final && !w_decoda)) begin
            // Abort or natural end of pulse; counter and code hold
            r_estado   <= REPOSO;
            r_s        <= '0;
            r_s_valido <= 1'b0;
            r_ocupado  <= 1'b0;
          end else if (w_decoda) begin
            // Reload on the final cycle: direct one-hot to one-hot switch
            r_cnt <= '0;
            r_cod <= bus.e;
            r_s   <= w_s_sig;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_estado <= REPOSO;
        end
      endcase
    end
  end

  assign bus.e_listo  = w_listo;
  assign bus.s        = r_s;
  assign bus.s_valido = r_s_valido;
  assign bus.ocupado  = r_ocupado;
  assign bus.estado   = r_estado;
  assign bus.codigo   = r_cod;
`ifdef DECOD_PARIDAD_EN
  assign bus.err_par  = r_err_par;
`endif

endmodule
